// File: rtl/bus_terminal_fifo.sv
// Terminal-side TX/RX FIFO pair for the shared-bus generator/arbiter.
// Optional destination filtering on RX is enabled by defining ADDR_FILTER_EN.
module bus_terminal_fifo_core #(
   parameter int unsigned W     = 16,
   parameter int unsigned depth = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic         full,
   output logic         ovf,
   output logic         vld,
   output logic [W-1:0] dout
);
   localparam int unsigned AW = $clog2(depth);

   logic [W-1:0]  mem [depth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt, cnt_nxt;
   logic          wr_ok, rd_ok;

   // A read on an empty FIFO is ignored; a write when full is only
   // accepted if a read frees the slot in the same cycle.
   always_comb begin
      rd_ok   = rd & vld;
      wr_ok   = wr & (~full | rd_ok);
      cnt_nxt = cnt;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_nxt = cnt + 1'b1;
         2'b01:   cnt_nxt = cnt - 1'b1;
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         vld    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         cnt  <= cnt_nxt;
         vld  <= (cnt_nxt != '0);
         full <= (cnt_nxt == (AW+1)'(depth));
         ovf  <= wr & full & ~rd_ok;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[wr_ptr] <= din;
   end

   assign dout = vld ? mem[rd_ptr] : '0;
endmodule

module bus_terminal_fifo #(
   parameter int unsigned pckg_sz   = 16,
   parameter int unsigned depth     = 8,
   parameter logic [7:0]  drv_id    = 8'd0,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_wr,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_full,
   output logic               tx_ovf,
   output logic               pndng,
   input  logic               pop,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               rx_rd,
   output logic [pckg_sz-1:0] rx_data,
   output logic               rx_vld,
`ifdef ADDR_FILTER_EN
   output logic [7:0]         drop_cnt,
`endif
   output logic               rx_ovf
);
   logic push_acc;
   logic rx_full_unused;

`ifdef ADDR_FILTER_EN
   logic [7:0] dst;
   logic       addr_ok;

   assign dst      = D_push[pckg_sz-1 -: 8];
   assign addr_ok  = (dst == drv_id) || (dst == broadcast);
   assign push_acc = push & addr_ok;

   // Filtered packets never reach the FIFO, so they cannot raise rx_ovf.
   always_ff @(posedge clk) begin
      if (reset)                                drop_cnt <= '0;
      else if (push && !addr_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{drv_id, broadcast};
   assign push_acc   = push;
`endif

   bus_terminal_fifo_core #(.W(pckg_sz), .depth(depth)) u_tx (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (pop),
      .full  (tx_full),
      .ovf   (tx_ovf),
      .vld   (pndng),
      .dout  (D_pop)
   );

   bus_terminal_fifo_core #(.W(pckg_sz), .depth(depth)) u_rx (
      .clk   (clk),
      .reset (reset),
      .wr    (push_acc),
      .din   (D_push),
      .rd    (rx_rd),
      .full  (rx_full_unused),
      .ovf   (rx_ovf),
      .vld   (rx_vld),
      .dout  (rx_data)
   );
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed self-checking bench for bus_terminal_fifo (depth 8, 16-bit packets).
module tb_bus_terminal_fifo;
   logic        clk = 1'b0;
   logic        reset;
   logic        tx_wr, pop, push, rx_rd;
   logic [15:0] tx_data, D_push;
   logic        tx_full, tx_ovf, pndng, rx_vld, rx_ovf;
   logic [15:0] D_pop, rx_data;
`ifdef ADDR_FILTER_EN
   logic [7:0]  drop_cnt;
`endif

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   bus_terminal_fifo #(.pckg_sz(16), .depth(8), .drv_id(8'd2), .broadcast(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_wr    (tx_wr),
      .tx_data  (tx_data),
      .tx_full  (tx_full),
      .tx_ovf   (tx_ovf),
      .pndng    (pndng),
      .pop      (pop),
      .D_pop    (D_pop),
      .push     (push),
      .D_push   (D_push),
      .rx_rd    (rx_rd),
      .rx_data  (rx_data),
      .rx_vld   (rx_vld),
`ifdef ADDR_FILTER_EN
      .drop_cnt (drop_cnt),
`endif
      .rx_ovf   (rx_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
   endtask

   initial begin
      reset = 1; idle(); tx_data = '0; D_push = '0;
      tick(); tick();
      reset = 0;
      chk("rst_pndng", pndng, 0);
      chk("rst_tx_full", tx_full, 0);
      chk("rst_rx_vld", rx_vld, 0);
      chk("rst_D_pop", D_pop, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_ovf", {tx_ovf, rx_ovf}, 0);

      // Single write/pop
      tx_wr = 1; tx_data = 16'h0A11; tick(); idle();
      chk("t1_pndng", pndng, 1);
      chk("t1_D_pop", D_pop, 16'h0A11);
      pop = 1; tick(); idle();
      chk("t1_pndng_after_pop", pndng, 0);
      chk("t1_D_pop_empty", D_pop, 0);

      // Fill TX, overflow, drain in order
      for (int i = 0; i < 8; i++) begin
         tx_wr = 1; tx_data = 16'h0100 + 16'(i); tick();
      end
      idle();
      chk("t2_full", tx_full, 1);
      chk("t2_no_ovf", tx_ovf, 0);
      tx_wr = 1; tx_data = 16'h0999; tick(); idle();
      chk("t2_ovf_pulse", tx_ovf, 1);
      chk("t2_full_kept", tx_full, 1);
      tick();
      chk("t2_ovf_clear", tx_ovf, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_pop%0d", i), D_pop, 16'h0100 + 16'(i));
         pop = 1; tick(); idle();
      end
      chk("t2_empty", pndng, 0);

      // Write + pop while full
      for (int i = 0; i < 8; i++) begin
         tx_wr = 1; tx_data = 16'h0200 + 16'(i); tick();
      end
      tx_wr = 1; tx_data = 16'hBEEF; pop = 1; tick(); idle();
      chk("t3_D_pop_adv", D_pop, 16'h0201);
      chk("t3_full_stays", tx_full, 1);
      chk("t3_no_ovf", tx_ovf, 0);
      for (int i = 0; i < 7; i++) begin
         pop = 1; tick(); idle();
      end
      chk("t3_beef", D_pop, 16'hBEEF);
      chk("t3_not_full", tx_full, 0);
      pop = 1; tick(); idle();
      chk("t3_empty", pndng, 0);

      // Write + pop while empty: pop ignored
      tx_wr = 1; tx_data = 16'h0777; pop = 1; tick(); idle();
      chk("empty_wrpop_pndng", pndng, 1);
      chk("empty_wrpop_D_pop", D_pop, 16'h0777);
      pop = 1; tick(); idle();

      // RX overflow and pointer wrap
      rx_rd = 1; tick(); idle();
      chk("rx_rd_empty_ignored", rx_vld, 0);
      for (int i = 0; i < 8; i++) begin
         push = 1; D_push = 16'h0300 + 16'(i); tick();
      end
      chk("t4_no_ovf", rx_ovf, 0);
      push = 1; D_push = 16'h03FF; tick(); idle();
      chk("t4_rx_ovf", rx_ovf, 1);
      chk("t4_rx_data_first", rx_data, 16'h0300);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("t4_mix%0d", i), rx_data,
             (i < 8) ? 16'h0300 + 16'(i) : 16'h0400 + 16'(i - 8));
         push = 1; rx_rd = 1; D_push = 16'h0400 + 16'(i); tick(); idle();
         chk($sformatf("t4_mix_noovf%0d", i), rx_ovf, 0);
      end
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t4_drain%0d", i), rx_data, 16'h0404 + 16'(i));
         rx_rd = 1; tick(); idle();
      end
      chk("t4_rx_empty", rx_vld, 0);

      // Reset with queued data; pop in reset cycle ignored
      for (int i = 0; i < 3; i++) begin
         tx_wr = 1; tx_data = 16'h0501 + 16'(i);
         push = 1;  D_push = 16'h0601 + 16'(i);
         tick();
      end
      idle();
      chk("t5_pre_pndng", pndng, 1);
      reset = 1; pop = 1; tick(); reset = 0; idle();
      chk("t5_pndng", pndng, 0);
      chk("t5_rx_vld", rx_vld, 0);
      chk("t5_D_pop", D_pop, 0);
      tx_wr = 1; tx_data = 16'h0800; tick(); idle();
      chk("t5_after_reset", D_pop, 16'h0800);
      pop = 1; tick(); idle();

`ifdef ADDR_FILTER_EN
      reset = 1; tick(); reset = 0;
      push = 1; D_push = 16'h02AA; tick();
      D_push = 16'hFF55; tick();
      D_push = 16'h0333; tick(); idle();
      chk("t6_drop_cnt", drop_cnt, 1);
      chk("t6_no_ovf", rx_ovf, 0);
      chk("t6_head0", rx_data, 16'h02AA);
      rx_rd = 1; tick(); idle();
      chk("t6_head1", rx_data, 16'hFF55);
      rx_rd = 1; tick(); idle();
      chk("t6_empty", rx_vld, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
